// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Sequences the shared game-object update engine from the divided frame tick.
//   Each of NUM_CH channels has a programmable period (in ticks). An expiring
//   channel is marked pending. Pending channels are granted round-robin to the
//   single engine through a start/done handshake. Sticky overrun flags record
//   expiries that arrive while a channel is still pending.
//
//   Optional build macro: TICK_WATCHDOG_EN
//     When defined, a WAIT that lasts WD_TICKS ticks without upd_done is aborted
//     and the sticky wd_timeout flag is set. When undefined, wd_timeout is 0 and
//     WAIT lasts until upd_done.
//
// Ports
//   cin          in   system clock
//   reset        in   asynchronous active-high reset
//   tick_in      in   one-cycle frame tick
//   cfg_we       in   period write strobe
//   cfg_ch       in   channel addressed by the write
//   cfg_period   in   new period (0 disables the channel)
//   upd_start    out  one-cycle start pulse to the engine
//   upd_ch       out  granted channel, valid while busy
//   upd_done     in   one-cycle completion pulse from the engine
//   busy         out  high from upd_start until completion
//   pending      out  channels expired but not yet granted
//   overrun      out  sticky: channel expired while already pending
//   overrun_clr  in   clears all overrun bits
//   wd_timeout   out  sticky watchdog flag
module tick_scheduler #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DEFAULT_PERIOD = 1,
    parameter int unsigned WD_TICKS       = 4
) (
    input  logic                      cin,
    input  logic                      reset,
    input  logic                      tick_in,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_period,
    output logic                      upd_start,
    output logic [$clog2(NUM_CH)-1:0] upd_ch,
    input  logic                      upd_done,
    output logic                      busy,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         overrun,
    input  logic                      overrun_clr,
    output logic                      wd_timeout
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("tick_scheduler: NUM_CH must be 2..8");
    end
    if (WD_TICKS < 1) begin : g_bad_wd_ticks
        $error("tick_scheduler: WD_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_period [NUM_CH];
    logic [CNT_W-1:0]   r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]  r_pending;
    logic [NUM_CH-1:0]  r_overrun;
    logic [CH_W-1:0]    r_upd_ch;
    logic [CH_W-1:0]    r_last;
    logic               r_upd_start;
    logic               r_busy;

    logic [NUM_CH-1:0]  w_cfg_hit;
    logic [NUM_CH-1:0]  w_expire;
    logic [NUM_CH-1:0]  w_issue_clr;
    logic [CH_W-1:0]    w_idx;
    logic [CH_W-1:0]    w_next;
    logic               w_found;

    // A config write to a channel suppresses its expiry on the same tick.
    always_comb begin
        w_cfg_hit   = '0;
        w_expire    = '0;
        w_issue_clr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cfg_hit[i]   = cfg_we && (cfg_ch == CH_W'(i));
            w_expire[i]    = tick_in && !w_cfg_hit[i] && (r_period[i] != '0) &&
                             (r_cnt[i] >= r_period[i] - CNT_W'(1));
            w_issue_clr[i] = (r_state == S_ISSUE) && (r_upd_ch == CH_W'(i));
        end
    end

    // Round-robin: first pending channel searching upward from last_grant+1.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((32'(r_last) + k) % NUM_CH);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    // Period/counter registers plus pending and overrun flags. Expiry wins
    // over the ISSUE clear, and a fresh overrun wins over overrun_clr.
    always_ff @(posedge cin or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_period[i] <= CNT_W'(DEFAULT_PERIOD);
                r_cnt[i]    <= '0;
            end
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_period[i] <= cfg_period;
                    r_cnt[i]    <= '0;
                end else if (tick_in) begin
                    if (r_period[i] == '0 || w_expire[i]) begin
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end
            end
            r_pending <= (r_pending & ~w_issue_clr) | w_expire;
            r_overrun <= (overrun_clr ? '0 : r_overrun) | (w_expire & r_pending);
        end
    end

`ifdef TICK_WATCHDOG_EN
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_wd_timeout;
`endif

    always_ff @(posedge cin or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_upd_ch    <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_upd_start <= 1'b0;
            r_busy      <= 1'b0;
`ifdef TICK_WATCHDOG_EN
            r_wd_cnt     <= '0;
            r_wd_timeout <= 1'b0;
`endif
        end else begin
            r_upd_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_upd_ch    <= w_next;
                        r_upd_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_last  <= r_upd_ch;
                    r_state <= S_WAIT;
`ifdef TICK_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (upd_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef TICK_WATCHDOG_EN
                    else if (tick_in) begin
                        // Abort on the WD_TICKS-th tick; the channel is not re-pended.
                        if (r_wd_cnt == CNT_W'(WD_TICKS - 1)) begin
                            r_busy       <= 1'b0;
                            r_wd_timeout <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                        end
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign upd_start = r_upd_start;
    assign upd_ch    = r_upd_ch;
    assign busy      = r_busy;
    assign pending   = r_pending;
    assign overrun   = r_overrun;
`ifdef TICK_WATCHDOG_EN
    assign wd_timeout = r_wd_timeout;
`else
    assign wd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    logic       cin;
    logic       reset;
    logic       tick_in;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       upd_start;
    logic [1:0] upd_ch;
    logic       upd_done;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       overrun_clr;
    logic       wd_timeout;

    logic       done_auto;
    logic       done_man;
    logic       eng_auto;
    logic [1:0] grant_q [$];

    int n_checks;
    int n_errors;

    assign upd_done = done_auto | done_man;

    tick_scheduler #(
        .NUM_CH         (4),
        .CNT_W          (8),
        .DEFAULT_PERIOD (1),
        .WD_TICKS       (4)
    ) dut (
        .cin         (cin),
        .reset       (reset),
        .tick_in     (tick_in),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .upd_start   (upd_start),
        .upd_ch      (upd_ch),
        .upd_done    (upd_done),
        .busy        (busy),
        .pending     (pending),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .wd_timeout  (wd_timeout)
    );

    initial cin = 1'b0;
    always #10 cin = ~cin;

    // Engine model: answers each upd_start with a done pulse one cycle later.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(posedge cin); #1;
            if (eng_auto && upd_start) begin
                @(posedge cin); #1;
                done_auto = 1'b1;
                @(posedge cin); #1;
                done_auto = 1'b0;
            end
        end
    end

    // Grant log.
    initial begin
        forever begin
            @(posedge cin); #1;
            if (upd_start) grant_q.push_back(upd_ch);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge cin); #1;
        end
    endtask

    task automatic pulse_tick();
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] per);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = per;
        cyc(1);
        cfg_we     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic check_grants(input string tag, input int n, input logic [1:0] exp_ch [$]);
        logic [31:0] g;
        check({tag, "_count"}, grant_q.size(), n);
        for (int i = 0; i < n; i++) begin
            g = (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF_FFFF;
            check({tag, "_ch"}, g, 32'(exp_ch[i]));
        end
    endtask

    initial begin
        logic [1:0] exp_q [$];
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        tick_in     = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_period  = '0;
        overrun_clr = 1'b0;
        done_man    = 1'b0;
        eng_auto    = 1'b0;

        // Reset state
        cyc(2);
        check("rst_upd_start", upd_start, 0);
        check("rst_upd_ch", upd_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 0);
        check("rst_wd", wd_timeout, 0);
        reset = 1'b0;
        cyc(1);

        // 1: default periods, three ticks, round-robin 0..3 each tick
        eng_auto = 1'b1;
        grant_q.delete();
        pulse_tick();
        check("t1_pend_lat", pending, 4'hF);
        check("t1_start_early", upd_start, 0);
        cyc(1);
        check("t1_start", upd_start, 1);
        check("t1_first_ch", upd_ch, 0);
        check("t1_busy", busy, 1);
        cyc(19);
        repeat (2) begin
            pulse_tick();
            cyc(20);
        end
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(2'(i % 4));
        check_grants("t1_grant", 12, exp_q);
        check("t1_overrun", overrun, 0);
        check("t1_pend_end", pending, 0);
        check("t1_busy_end", busy, 0);

        // 2: ch2 period 3, others disabled
        grant_q.delete();
        cfg_write(2'd2, 8'd3);
        cfg_write(2'd0, 8'd0);
        cfg_write(2'd1, 8'd0);
        cfg_write(2'd3, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            pulse_tick();
            check($sformatf("t2_pend_tick%0d", k), pending, (k % 3 == 0) ? 4'b0100 : 4'b0000);
            cyc(10);
        end
        exp_q.delete();
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        check_grants("t2_grant", 2, exp_q);

        // 3: engine stalls; overrun and overrun_clr
        eng_auto = 1'b0;
        do_reset();
        pulse_tick();
        cyc(2);
        check("t3_busy", busy, 1);
        check("t3_ch", upd_ch, 0);
        check("t3_pend", pending, 4'b1110);
        check("t3_ovr0", overrun, 0);
        pulse_tick();
        check("t3_ovr", overrun, 4'b1110);
        check("t3_pend2", pending, 4'b1111);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        check("t3_ovr_clr", overrun, 0);
        check("t3_busy_hold", busy, 1);

        // 4: config write coinciding with an expiring tick
        do_reset();
        eng_auto = 1'b1;
        cfg_write(2'd0, 8'd0);
        cfg_write(2'd2, 8'd0);
        cfg_write(2'd3, 8'd0);
        grant_q.delete();
        pulse_tick();
        check("t4_pend_a", pending, 4'b0010);
        cyc(10);
        tick_in    = 1'b1;
        cfg_we     = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = 8'd2;
        cyc(1);
        tick_in = 1'b0;
        cfg_we  = 1'b0;
        check("t4_pend_wr", pending, 4'b0000);
        cyc(5);
        pulse_tick();
        check("t4_pend_b", pending, 4'b0000);
        cyc(5);
        pulse_tick();
        check("t4_pend_c", pending, 4'b0010);
        cyc(10);
        exp_q.delete();
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        check_grants("t4_grant", 2, exp_q);

        // 5: reset during WAIT with upd_ch=1
        eng_auto = 1'b0;
        do_reset();
        cfg_write(2'd0, 8'd0);
        cfg_write(2'd2, 8'd0);
        cfg_write(2'd3, 8'd0);
        pulse_tick();
        cyc(3);
        check("t5_busy_pre", busy, 1);
        check("t5_ch_pre", upd_ch, 1);
        reset = 1'b1;
        #1;
        check("t5_busy_async", busy, 0);
        check("t5_ch_async", upd_ch, 0);
        check("t5_pend_async", pending, 0);
        check("t5_start_async", upd_start, 0);
        cyc(1);
        reset = 1'b0;
        done_man = 1'b1;
        cyc(1);
        done_man = 1'b0;
        cyc(2);
        check("t5_busy_post", busy, 0);
        check("t5_start_post", upd_start, 0);
        check("t5_pend_post", pending, 0);
        eng_auto = 1'b1;
        pulse_tick();
        check("t5_pend_tick", pending, 4'hF);
        cyc(1);
        check("t5_start_next", upd_start, 1);
        check("t5_ch_next", upd_ch, 0);
        cyc(20);

`ifdef TICK_WATCHDOG_EN
        // 6: watchdog aborts a stalled WAIT after WD_TICKS ticks
        eng_auto = 1'b0;
        do_reset();
        pulse_tick();
        cyc(2);
        check("t6_busy_wait", busy, 1);
        for (int t = 1; t <= 3; t++) begin
            pulse_tick();
            check($sformatf("t6_wd_pre%0d", t), wd_timeout, 0);
            check($sformatf("t6_busy_pre%0d", t), busy, 1);
            cyc(1);
        end
        pulse_tick();
        check("t6_wd", wd_timeout, 1);
        check("t6_busy", busy, 0);
        cyc(1);
        check("t6_start", upd_start, 1);
        check("t6_ch", upd_ch, 1);
        cyc(3);
        check("t6_wd_sticky", wd_timeout, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
